core_ctrl: RTL
==============

# core_ctrl

Multicore coordinator that sits between the four pipelined cores and the top level. It consumes each core's write-back-stage requests: awaken (`pc_out`) and pause/resume (`pauseResume`). It drives each core's `pc_passed` wake-up pulse and `stall_num` freeze level, and tracks a per-core run state. It also boots one core out of reset and reports global completion and deadlock to the testbench/top.

## Interface

Parameters:
- `BOOT_CORE`, 0: core started automatically after reset.
- `BOOT_PC`, 16'h0000: start PC given to `BOOT_CORE`.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pause_resume_i`  in  16  core n at [4n+3:4n]; bit3 valid, bit2 1=resume/0=pause, [1:0] target core.
- `pc_req_i`  in  76  core n at [19n+18:19n]; bit18 awaken valid, [17:16] target core, [15:0] start PC.
- `halt_i`  in  4  per-core halt flag (level).
- `awake_i`  in  4  per-core awake flag; used only for the consistency check.
- `pc_passed_o`  out  68  core n at [17n+16:17n]; bit16 one-cycle wake pulse, [15:0] PC.
- `stall_num_o`  out  12  core n at [3n+2:3n]; 3'd6 while paused, else 3'd0.
- `done_o`  out  1  boot complete and no core RUN or PAUSED.
- `deadlock_o`  out  1  no core RUN and at least one core PAUSED.

## Operation

- Each core has a state: SLEEP, RUN, PAUSED, HALTED. On reset all cores are SLEEP and `boot_done` is 0.
- **Boot:** at the first rising edge after `rst` falls:
  - `pc_passed_o[BOOT_CORE]` becomes {1, `BOOT_PC`}.
  - `BOOT_CORE` goes to RUN and `boot_done` is set.
  - Requests sampled at that edge are ignored.
- **Requests are idempotent.** A core's write-back stage may present the same request for several cycles while stalled. Repeats must be harmless.
- **Awaken:** target SLEEP → RUN, and that target's `pc_passed_o` pulses with the requested PC.
  - Awaken of a RUN, PAUSED or HALTED target is ignored.
  - If several cores request the same SLEEP target in one cycle, the lowest-numbered requester wins. The rest are dropped.
- **Pause:** target RUN → PAUSED. **Resume:** target PAUSED → RUN.
  - Any other combination is ignored (e.g. pause of SLEEP, resume of RUN).
  - If pause and resume for the same target arrive in the same cycle, resume wins. A PAUSED target stays resumed; a RUN target stays RUN.
  - A core may pause itself. Only another core can resume it.
- **Halt:** `halt_i[n]`=1 moves core n to HALTED from any state. HALTED is terminal until `rst`. Halt overrides every request targeting n in the same cycle.
- Requests from a core in SLEEP or HALTED are ignored. Requests from a PAUSED core are accepted, since its WB stage is frozen with the request still visible.
- **Outputs:**
  - `stall_num_o[n]` = 6 iff state PAUSED.
  - `pc_passed_o[n]` bit16 = 1 for exactly one cycle per SLEEP→RUN transition; [15:0] holds the last value.
  - `done_o` = `boot_done` and no RUN/PAUSED core.
  - `deadlock_o` = no RUN core and at least one PAUSED core.
- **Consistency check (simulation only):** `$display` an error if `awake_i[n]`=0 while core n has been RUN/PAUSED for 2 or more cycles.

## Timing

- All outputs are registered. Reset values: `pc_passed_o`=0, `stall_num_o`=0, `done_o`=0, `deadlock_o`=0.
- A request sampled at edge N changes state at edge N. `stall_num_o` and `pc_passed_o` reflect it during cycle N+1 (1-cycle latency).
- The wake pulse is high during cycle N+1 only and is deasserted at edge N+1.
- `rst` asserted mid-operation immediately clears all state and outputs, including an in-flight wake pulse. Boot repeats after release.

## Structure

- Package `core_ctrl_pkg` holds:
  - the state enum (SLEEP/RUN/PAUSED/HALTED);
  - `STALL_ALL`=3'd6;
  - `NCORES`=4;
  - the field offsets/widths of the pause_resume, pc_req and pc_passed slices.
- Sub-module `core_ctrl_slot` (instantiated ×4) contains:
  - inputs: per-core FSM driven by decoded wake/pause/resume/halt strobes;
  - outputs: its own `pc_passed`, `stall_num`, and a state register.
- The top level performs:
  - request routing, with lowest-requester priority and resume-over-pause resolution;
  - boot sequencing;
  - `done_o`/`deadlock_o` reduction.

## Test plan

- Reset release with `BOOT_CORE`=0, `BOOT_PC`=16'h0000 → next cycle `pc_passed_o[0]`=17'h10000 for one cycle; `stall_num_o` all 0; `done_o`=0.
- Core 0 awakens core 2 at PC 16'h0100, held 3 cycles → exactly one pulse `pc_passed_o[2]`=17'h10100; core 2 RUN; later repeats are ignored.
- Cores 0 and 1 both awaken core 3 in the same cycle (PCs 16'h0200 and 16'h0300) → core 3 receives 16'h0200.
- Core 0 pauses core 1 → `stall_num_o[1]`=6 from the next cycle. Pause and resume for core 1 in the same cycle → `stall_num_o[1]`=0.
- Core 1 pauses itself, then core 0 halts → `deadlock_o`=1, `done_o`=0. Core 1 halts instead → `done_o`=1.
- `rst` pulsed during the cycle of a wake pulse → pulse cleared immediately; boot pulse reissued after release.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared types and bus-slice layout for the multicore coordinator.
package core_ctrl_pkg;

    localparam int NCORES = 4;

    typedef enum logic [1:0] {
        ST_SLEEP  = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_HALTED = 2'd3
    } core_state_t;

    localparam logic [2:0] STALL_ALL = 3'd6;

    localparam int PC_W  = 16;
    localparam int TGT_W = 2;

    // pause_resume slice: {valid, resume, target[1:0]}
    localparam int PR_W   = 4;
    localparam int PR_VLD = 3;
    localparam int PR_RES = 2;
    localparam int PR_TGT = 0;

    // pc_req slice: {valid, target[1:0], pc[15:0]}
    localparam int PCR_W   = 19;
    localparam int PCR_VLD = 18;
    localparam int PCR_TGT = 16;
    localparam int PCR_PC  = 0;

    // pc_passed slice: {pulse, pc[15:0]}
    localparam int PCP_W   = 17;
    localparam int PCP_VLD = 16;

    localparam int STALL_W = 3;

    function automatic logic is_live(input logic [1:0] s);
        return (s == ST_RUN) || (s == ST_PAUSED);
    endfunction

endpackage

// File: rtl/core_ctrl_slot.sv
// Per-core run-state FSM with registered wake pulse and stall level.
module core_ctrl_slot
    import core_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wake,
    input  logic [PC_W-1:0]    i_wake_pc,
    input  logic               i_pause,
    input  logic               i_resume,
    input  logic               i_halt,
    output logic [1:0]         o_state,
    output logic [1:0]         o_nxt_state,
    output logic [PCP_W-1:0]   o_pc_passed,
    output logic [STALL_W-1:0] o_stall_num
);

    core_state_t        r_state;
    core_state_t        w_nxt;
    logic               w_wake_ok;
    logic               r_pulse;
    logic [PC_W-1:0]    r_pc;
    logic [STALL_W-1:0] r_stall;

    always_comb begin
        w_nxt     = r_state;
        w_wake_ok = 1'b0;
        case (r_state)
            ST_SLEEP: begin
                if (i_wake) begin
                    w_nxt     = ST_RUN;
                    w_wake_ok = 1'b1;
                end
            end
            // Resume dominates: a RUN core seeing both stays RUN.
            ST_RUN:    if (i_pause && !i_resume) w_nxt = ST_PAUSED;
            ST_PAUSED: if (i_resume) w_nxt = ST_RUN;
            default:   w_nxt = ST_HALTED;
        endcase
        if (i_halt) begin
            w_nxt     = ST_HALTED;
            w_wake_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SLEEP;
            r_pulse <= 1'b0;
            r_pc    <= '0;
            r_stall <= '0;
        end else begin
            r_state <= w_nxt;
            r_pulse <= w_wake_ok;
            if (w_wake_ok) r_pc <= i_wake_pc;
            r_stall <= (w_nxt == ST_PAUSED) ? STALL_ALL : '0;
        end
    end

    assign o_state     = r_state;
    assign o_nxt_state = w_nxt;
    assign o_pc_passed = {r_pulse, r_pc};
    assign o_stall_num = r_stall;

endmodule

// File: rtl/core_ctrl.sv
// Multicore coordinator: routes awaken/pause/resume requests between cores,
// boots one core out of reset and reports completion/deadlock.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int              BOOT_CORE = 0,
    parameter logic [PC_W-1:0] BOOT_PC   = 16'h0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NCORES*PR_W-1:0]      pause_resume_i,
    input  logic [NCORES*PCR_W-1:0]     pc_req_i,
    input  logic [NCORES-1:0]           halt_i,
    input  logic [NCORES-1:0]           awake_i,
    output logic [NCORES*PCP_W-1:0]     pc_passed_o,
    output logic [NCORES*STALL_W-1:0]   stall_num_o,
    output logic                        done_o,
    output logic                        deadlock_o
);

    logic                              r_boot_done;
    logic                              r_done;
    logic                              r_deadlock;

    logic [NCORES-1:0]                 w_pr_vld, w_pr_res, w_pc_vld, w_active;
    logic [NCORES-1:0][TGT_W-1:0]      w_pr_tgt, w_pc_tgt;
    logic [NCORES-1:0][PC_W-1:0]       w_req_pc, w_wake_pc;
    logic [NCORES-1:0]                 w_wake, w_pause, w_resume;
    logic [NCORES-1:0][1:0]            w_state, w_nxt_state;
    logic [NCORES-1:0][PCP_W-1:0]      w_pc_passed;
    logic [NCORES-1:0][STALL_W-1:0]    w_stall;
    logic                              w_nxt_run, w_nxt_pause;

    for (genvar n = 0; n < NCORES; n++) begin : g_core
        assign w_pr_vld[n] = pause_resume_i[n*PR_W + PR_VLD];
        assign w_pr_res[n] = pause_resume_i[n*PR_W + PR_RES];
        assign w_pr_tgt[n] = pause_resume_i[n*PR_W + PR_TGT +: TGT_W];
        assign w_pc_vld[n] = pc_req_i[n*PCR_W + PCR_VLD];
        assign w_pc_tgt[n] = pc_req_i[n*PCR_W + PCR_TGT +: TGT_W];
        assign w_req_pc[n] = pc_req_i[n*PCR_W + PCR_PC +: PC_W];
        // A paused core's WB stage is frozen but its request stays valid.
        assign w_active[n] = is_live(w_state[n]);

        core_ctrl_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .i_wake      (w_wake[n]),
            .i_wake_pc   (w_wake_pc[n]),
            .i_pause     (w_pause[n]),
            .i_resume    (w_resume[n]),
            .i_halt      (halt_i[n]),
            .o_state     (w_state[n]),
            .o_nxt_state (w_nxt_state[n]),
            .o_pc_passed (w_pc_passed[n]),
            .o_stall_num (w_stall[n])
        );
    end

    always_comb begin
        w_wake    = '0;
        w_wake_pc = '0;
        w_pause   = '0;
        w_resume  = '0;
        if (!r_boot_done) begin
            w_wake[BOOT_CORE]    = 1'b1;
            w_wake_pc[BOOT_CORE] = BOOT_PC;
        end else begin
            for (int t = 0; t < NCORES; t++) begin
                // Scan high to low so the lowest-numbered requester lands last.
                for (int r = NCORES - 1; r >= 0; r--) begin
                    if (w_active[r] && w_pc_vld[r] && w_pc_tgt[r] == TGT_W'(t)) begin
                        w_wake[t]    = 1'b1;
                        w_wake_pc[t] = w_req_pc[r];
                    end
                    if (w_active[r] && w_pr_vld[r] && w_pr_tgt[r] == TGT_W'(t)) begin
                        if (!w_pr_res[r])
                            w_pause[t] = 1'b1;
                        else if (r != t)
                            w_resume[t] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_nxt_run   = 1'b0;
        w_nxt_pause = 1'b0;
        for (int n = 0; n < NCORES; n++) begin
            w_nxt_run   = w_nxt_run   | (w_nxt_state[n] == ST_RUN);
            w_nxt_pause = w_nxt_pause | (w_nxt_state[n] == ST_PAUSED);
        end
    end

    // Any non-reset edge completes boot, so the next boot_done is always 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_boot_done <= 1'b0;
            r_done      <= 1'b0;
            r_deadlock  <= 1'b0;
        end else begin
            r_boot_done <= 1'b1;
            r_done      <= !(w_nxt_run || w_nxt_pause);
            r_deadlock  <= !w_nxt_run && w_nxt_pause;
        end
    end

    assign pc_passed_o = w_pc_passed;
    assign stall_num_o = w_stall;
    assign done_o      = r_done;
    assign deadlock_o  = r_deadlock;

`ifndef SYNTHESIS
    logic [NCORES-1:0][1:0] r_live_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live_cnt <= '0;
        end else begin
            for (int n = 0; n < NCORES; n++) begin
                if (w_active[n]) begin
                    if (r_live_cnt[n] == 2'd2 && !awake_i[n])
                        $display("core_ctrl: error: core %0d live without awake_i", n);
                    r_live_cnt[n] <= (r_live_cnt[n] == 2'd2) ? 2'd2 : r_live_cnt[n] + 2'd1;
                end else begin
                    r_live_cnt[n] <= 2'd0;
                end
            end
        end
    end
`endif

endmodule
